// File: rtl/frec_meter.sv
// Measures SIG_IN period in clk_i cycles; result lags SIG_IN by SYNC_STAGES+1 cycles, no backpressure.
// Optional HIGH_TIME duty output under FREC_METER_DUTY_EN.
module frec_meter #(
   parameter int CNT_W       = 24,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_PERIOD  = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             sig_in_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] period_o,
   output logic             valid_o,
   output logic             timeout_o,
   output logic             locked_o
`ifdef FREC_METER_DUTY_EN
   ,
   output logic [CNT_W-1:0] high_time_o
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_MEAS = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sig_s;
   logic                   rise;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic             locked_q, locked_d;
`ifdef FREC_METER_DUTY_EN
   logic [CNT_W-1:0] hi_q, hi_d;
   logic [CNT_W-1:0] high_q, high_d;
`endif

   assign sig_s = sync_q[SYNC_STAGES-1];
   assign rise  = sig_s & ~prev_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      locked_d  = locked_q;
`ifdef FREC_METER_DUTY_EN
      hi_d      = hi_q;
      high_d    = high_q;
`endif
      if (clr_i) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         locked_d  = 1'b0;
         timeout_d = 1'b0;
`ifdef FREC_METER_DUTY_EN
         hi_d      = '0;
         high_d    = '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rise) begin
                  state_d = ST_ARM;
                  cnt_d   = CNT_ONE;
`ifdef FREC_METER_DUTY_EN
                  hi_d    = CNT_ONE;
`endif
               end
            end
            ST_ARM, ST_MEAS: begin
               if (rise) begin
                  // Short intervals are glitches: window restarts, outputs untouched.
                  if (cnt_q >= MIN_P) begin
                     period_d  = cnt_q;
                     valid_d   = 1'b1;
                     locked_d  = 1'b1;
                     timeout_d = 1'b0;
`ifdef FREC_METER_DUTY_EN
                     high_d    = hi_q;
`endif
                  end
                  state_d = ST_MEAS;
                  cnt_d   = CNT_ONE;
`ifdef FREC_METER_DUTY_EN
                  hi_d    = CNT_ONE;
`endif
               end else if (cnt_q == CNT_MAX) begin
                  state_d   = ST_IDLE;
                  cnt_d     = '0;
                  timeout_d = 1'b1;
                  locked_d  = 1'b0;
`ifdef FREC_METER_DUTY_EN
                  hi_d      = '0;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
`ifdef FREC_METER_DUTY_EN
                  hi_d  = hi_q + {{(CNT_W-1){1'b0}}, sig_s};
`endif
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q    <= '0;
         prev_q    <= 1'b0;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         locked_q  <= 1'b0;
`ifdef FREC_METER_DUTY_EN
         hi_q      <= '0;
         high_q    <= '0;
`endif
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in_i};
         prev_q    <= sig_s;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         locked_q  <= locked_d;
`ifdef FREC_METER_DUTY_EN
         hi_q      <= hi_d;
         high_q    <= high_d;
`endif
      end
   end

   assign period_o  = period_q;
   assign valid_o   = valid_q;
   assign timeout_o = timeout_q;
   assign locked_o  = locked_q;
`ifdef FREC_METER_DUTY_EN
   assign high_time_o = high_q;
`endif

endmodule

// File: doc/frec_meter.md
Name: frec_meter

Overview:
- Measurement-side counterpart to the N_Frec clock divider. Takes the divided square wave (e.g. N_Frec CLK2) on SIG_IN.
- Counts system CLK cycles between consecutive rising edges of SIG_IN and reports the period with a one-cycle valid strobe.
- Flags loss of signal with a timeout.
- Sits next to N_Frec so the board and bench can check the divider ratio in hardware.

Parameters:
- CNT_W, 24, width of the period counter and PERIOD output.
- SYNC_STAGES, 2, number of synchronizer flops on SIG_IN; legal values 2..4.
- MIN_PERIOD, 4, measured periods below this value are rejected as glitches.

Ports:
- CLK  input  1  system clock, all logic on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- SIG_IN  input  1  asynchronous square wave to be measured.
- CLR  input  1  synchronous clear: drops any measurement in progress and returns to IDLE.
- PERIOD  output  CNT_W  last accepted period in CLK cycles.
- VALID  output  1  one-cycle pulse when PERIOD updates.
- TIMEOUT  output  1  sticky flag: no edge within 2^CNT_W-1 cycles.
- LOCKED  output  1  high while at least one valid period has been measured and no timeout has occurred since.

Behaviour:
- Reset (RST_N=0, asynchronous): PERIOD=0, VALID=0, TIMEOUT=0, LOCKED=0, counter=0, synchronizer flops=0, FSM=IDLE.
- SIG_IN passes through SYNC_STAGES flops. A rising edge is a registered 0->1 on the synchronizer output.
  - Edge detect lags SIG_IN by SYNC_STAGES+1 cycles.
  - The lag is constant, so it does not affect the measured period.
- FSM states: IDLE, ARM, MEAS.
  - IDLE: waits for the first rising edge. On the edge: counter<=1, go to ARM.
  - ARM: no previous edge-to-edge interval exists yet. Counter increments each cycle. On the next edge: evaluate the period, counter<=1, go to MEAS.
  - MEAS: counter increments each cycle. On each edge: evaluate the period, counter<=1, stay in MEAS.
- Period evaluation (registered), with cnt = counter value at the edge:
  - If cnt >= MIN_PERIOD: PERIOD<=cnt, VALID=1 for exactly that cycle, LOCKED<=1, TIMEOUT<=0.
  - Otherwise: no update, VALID stays 0, counter restarts at 1.
- VALID must never be high on two consecutive cycles.
- Timeout:
  - In ARM or MEAS, if counter reaches 2^CNT_W-1 without an edge: TIMEOUT<=1, LOCKED<=0, PERIOD held, FSM->IDLE, counter<=0.
  - The counter saturates and never wraps.
- TIMEOUT clears only on the next accepted period, on CLR, or on reset.
- CLR=1: FSM->IDLE, counter<=0, LOCKED<=0, TIMEOUT<=0, PERIOD held.
  - CLR has priority over an edge in the same cycle.
- Reset asserted mid-measurement: all state returns to reset values at once. No VALID pulse is produced.

Optional Feature:
- Macro: FREC_METER_DUTY_EN.
- When defined:
  - Adds output HIGH_TIME [CNT_W-1:0], reset 0. It counts cycles with the synchronized SIG_IN high within the same edge-to-edge window.
  - HIGH_TIME updates together with PERIOD, under the same VALID and MIN_PERIOD rules.
  - It is cleared by CLR and held on timeout.
- When not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- SIG_IN toggles every 10 CLK cycles (N_Frec-style /20) -> first VALID after the second rising edge; PERIOD=20 on every later VALID; LOCKED=1; TIMEOUT=0.
- SIG_IN changes from a /20 wave to a /50 wave mid-run -> one transitional VALID with an intermediate value; every later VALID has PERIOD=50.
- SIG_IN held at 0 after locking, CNT_W=8 -> 255 cycles after the last edge: TIMEOUT=1, LOCKED=0, PERIOD=20 held; the next two edges 30 cycles apart give PERIOD=30 and TIMEOUT=0.
- Glitch pulse 2 cycles after an edge, MIN_PERIOD=4 -> no VALID for the 2-cycle interval; the counter restarts and the following interval is reported.
- CLR asserted in the same cycle as a detected edge -> no VALID, FSM=IDLE; RST_N pulsed low mid-count -> all outputs 0 asynchronously.
- With FREC_METER_DUTY_EN, SIG_IN high 6 cycles and low 14 cycles -> PERIOD=20, HIGH_TIME=6 on each VALID.
